freq_step_ctrl: RTL and testbench



---
 rtl/freq_step_pkg.sv | 8 +
 rtl/tick_divider.sv | 53 +++++
 rtl/freq_step_ctrl.sv | 103 ++++++++++
 tb/tb_freq_step_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/freq_step_pkg.sv
// Shared types and constants for the frequency step controller.
package freq_step_pkg;
  localparam int SEL_W_DEF = 3;
  localparam int DIV_W_DEF = 8;
  localparam int SEL_MAX   = 7;

  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/tick_divider.sv
// Programmable period divider: counts 0..div_q-1 while run is high, emits a
// registered one-cycle tick and toggles wave at each terminal count. The
// divisor is re-latched at every terminal count (and continuously while
// stopped), so a new divisor only takes effect from the next period.
module tick_divider
  import freq_step_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             wave,
  output logic             load
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nz;
  logic             term;

  // A zero divisor behaves as one: tick every cycle.
  assign div_nz = (div == '0) ? DIV_W'(1) : div;
  // Compare before increment, so cnt never wraps.
  assign term   = (cnt == div_q - DIV_W'(1));
  assign load   = run & term;

  // Counter, divisor latch, tick and wave generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
      tick  <= 1'b0;
      wave  <= 1'b0;
    end else if (!run) begin
      cnt   <= '0;
      div_q <= div_nz;
      tick  <= 1'b0;
      wave  <= 1'b0;
    end else if (term) begin
      cnt   <= '0;
      div_q <= div_nz;
      tick  <= 1'b1;
      wave  <= ~wave;
    end else begin
      cnt   <= cnt + DIV_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_step_ctrl.sv
// Select stepping controller for the divisor table. Holds the table select,
// steps it on Up_i/Down_i pulses, flags a pending divisor change, and runs
// the tick divider while enabled.
// Build option: define FREQ_STEP_WRAP_EN to make the select wrap at 0/7
// instead of saturating.
module freq_step_ctrl
  import freq_step_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             En_i,
  input  logic             Up_i,
  input  logic             Down_i,
  input  logic [DIV_W-1:0] Div_i,
  output logic [SEL_W-1:0] Sel_o,
  output logic             Tick_o,
  output logic             Wave_o,
  output logic             Pend_o
);

  localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(SEL_MAX);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             run, load, wave, pend_clr;

  assign run    = (state == RUN);
  // Wave is held low for the whole time the block is stopped.
  assign Wave_o = wave & run;

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk  (clk_i),
    .rst  (rst_i),
    .run  (run),
    .div  (Div_i),
    .tick (Tick_o),
    .wave (wave),
    .load (load)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; a divisor load (start of run or terminal count) clears pending.
  always_comb begin
    state_nxt = state;
    pend_clr  = load;
    case (state)
      IDLE: if (En_i) begin
        state_nxt = RUN;
        pend_clr  = 1'b1;
      end
      RUN:  if (!En_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step logic: simultaneous up and down cancel; bounds saturate or wrap.
  always_comb begin
    sel_nxt = Sel_o;
    if (Up_i && !Down_i) begin
      if (Sel_o == SEL_TOP) begin
`ifdef FREQ_STEP_WRAP_EN
        sel_nxt = '0;
`else
        sel_nxt = Sel_o;
`endif
      end else begin
        sel_nxt = Sel_o + SEL_W'(1);
      end
    end else if (Down_i && !Up_i) begin
      if (Sel_o == '0) begin
`ifdef FREQ_STEP_WRAP_EN
        sel_nxt = SEL_TOP;
`else
        sel_nxt = Sel_o;
`endif
      end else begin
        sel_nxt = Sel_o - SEL_W'(1);
      end
    end
  end

  // Select register and pending flag; a change on a load edge stays pending
  // because the divisor latched on that edge belongs to the old select.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Sel_o  <= '0;
      Pend_o <= 1'b0;
    end else begin
      Sel_o <= sel_nxt;
      if (sel_nxt != Sel_o) Pend_o <= 1'b1;
      else if (pend_clr)    Pend_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Directed bench for freq_step_ctrl with a behavioural divisor table.
module tb_freq_step_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i, En_i, Up_i, Down_i;
  logic [7:0] Div_i;
  logic [2:0] Sel_o;
  logic       Tick_o, Wave_o, Pend_o;

  int n_chk  = 0;
  int n_fail = 0;
  int n;
  logic w;

  logic [7:0] tbl [8] = '{8'd165, 8'd99, 8'd50, 8'd30, 8'd12, 8'd7, 8'd1, 8'd0};

  freq_step_ctrl dut (
    .clk_i (clk_i), .rst_i (rst_i), .En_i (En_i), .Up_i (Up_i),
    .Down_i(Down_i), .Div_i (Div_i), .Sel_o (Sel_o), .Tick_o(Tick_o),
    .Wave_o(Wave_o), .Pend_o(Pend_o)
  );

  always #5 clk_i = ~clk_i;

  // Combinational table feeding the divisor back.
  always_comb Div_i = tbl[Sel_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Cycles until Tick_o is seen high, bounded.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      cnt++;
      if (Tick_o === 1'b1) break;
    end
  endtask

  task automatic pulse_up();
    Up_i = 1'b1; step(); Up_i = 1'b0;
  endtask

  task automatic pulse_dn();
    Down_i = 1'b1; step(); Down_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; En_i = 1'b0; Up_i = 1'b0; Down_i = 1'b0;
    steps(3);
    chk("rst_sel", Sel_o, 0);
    chk("rst_tick", Tick_o, 0);
    chk("rst_wave", Wave_o, 0);
    chk("rst_pend", Pend_o, 0);

    // Run at sel 0, divisor 165.
    rst_i = 1'b0; En_i = 1'b1;
    wait_tick(n);
    chk("first_tick", n, 166);
    chk("first_wave", Wave_o, 1);
    chk("first_pend", Pend_o, 0);
    wait_tick(n);
    chk("period165", n, 165);
    chk("wave_low", Wave_o, 0);

    // Step up mid-period: current period unchanged, next one 99.
    steps(50);
    pulse_up();
    chk("up_sel", Sel_o, 1);
    chk("up_pend", Pend_o, 1);
    wait_tick(n);
    chk("mid_step_tick", n, 114);
    chk("pend_cleared", Pend_o, 0);
    wait_tick(n);
    chk("period99", n, 99);

    // To sel 3, then simultaneous up/down.
    pulse_up();
    pulse_up();
    chk("sel3", Sel_o, 3);
    wait_tick(n);
    chk("tick_97", n, 97);
    chk("pend3_clr", Pend_o, 0);
    Up_i = 1'b1; Down_i = 1'b1; step(); Up_i = 1'b0; Down_i = 1'b0;
    chk("both_sel", Sel_o, 3);
    chk("both_pend", Pend_o, 0);
    wait_tick(n);
    chk("tick_29", n, 29);
    wait_tick(n);
    chk("period30", n, 30);
    chk("wave_hi_30", Wave_o, 1);

    // Disable mid-period, re-enable 10 cycles later.
    steps(10);
    En_i = 1'b0;
    step();
    chk("idle_wave", Wave_o, 0);
    chk("idle_sel", Sel_o, 3);
    steps(10);
    chk("idle_tick", Tick_o, 0);
    chk("idle_wave2", Wave_o, 0);
    En_i = 1'b1;
    wait_tick(n);
    chk("reentry_tick", n, 31);
    chk("reentry_wave", Wave_o, 1);

    // To sel 7: zero divisor runs at one cycle per tick.
    for (int i = 0; i < 4; i++) pulse_up();
    chk("sel7", Sel_o, 7);
    chk("sel7_pend", Pend_o, 1);
    wait_tick(n);
    chk("tick_26", n, 26);
    chk("sel7_pend_clr", Pend_o, 0);
    step();
    chk("div0_tick_a", Tick_o, 1);
    w = Wave_o;
    step();
    chk("div0_tick_b", Tick_o, 1);
    chk("div0_wave", Wave_o, {31'd0, ~w});

    // Bounds, checked while stopped so pending is not cleared by loads.
    En_i = 1'b0;
    steps(2);
    pulse_up();
`ifdef FREQ_STEP_WRAP_EN
    chk("up_at_max_sel", Sel_o, 0);
    chk("up_at_max_pend", Pend_o, 1);
    pulse_dn();
`else
    chk("up_at_max_sel", Sel_o, 7);
    chk("up_at_max_pend", Pend_o, 0);
`endif
    for (int i = 0; i < 7; i++) pulse_dn();
    chk("sel0", Sel_o, 0);
    chk("sel0_pend", Pend_o, 1);
    En_i = 1'b1;
    step();
    chk("entry_pend_clr", Pend_o, 0);
    pulse_dn();
`ifdef FREQ_STEP_WRAP_EN
    chk("dn_at_min_sel", Sel_o, 7);
    chk("dn_at_min_pend", Pend_o, 1);
    pulse_dn();
    pulse_dn();
`else
    chk("dn_at_min_sel", Sel_o, 0);
    chk("dn_at_min_pend", Pend_o, 0);
    for (int i = 0; i < 5; i++) pulse_up();
`endif
    chk("sel5", Sel_o, 5);
    chk("sel5_pend", Pend_o, 1);

    // Asynchronous reset mid-run.
    steps(20);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_sel", Sel_o, 0);
    chk("arst_tick", Tick_o, 0);
    chk("arst_wave", Wave_o, 0);
    chk("arst_pend", Pend_o, 0);
    step();
    rst_i = 1'b0;
    wait_tick(n);
    chk("post_rst_tick", n, 166);
    chk("post_rst_sel", Sel_o, 0);
    wait_tick(n);
    chk("post_rst_period", n, 165);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
